// File: rtl/modem_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | modem_pkg : shared widths and sequencer state encoding                   |
// | Revision  : 1.0                                                          |
// +--------------------------------------------------------------------------+
package modem_pkg;

  localparam int DATA_W = 4;
  localparam int CODE_W = 8;

  typedef logic [DATA_W-1:0] data_t;

  localparam data_t MAX_CODE = 4'hF;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] DRIVE  = 3'd1;
  localparam logic [2:0] SETTLE = 3'd2;
  localparam logic [2:0] SAMPLE = 3'd3;
  localparam logic [2:0] NEXT   = 3'd4;
  localparam logic [2:0] DONE   = 3'd5;

  // The sequencer owns tx_code only in the sweep states.
  function automatic logic is_busy_state(input logic [2:0] st);
    return (st == DRIVE) || (st == SETTLE) || (st == SAMPLE) || (st == NEXT);
  endfunction

endpackage
`default_nettype wire

// File: rtl/modem_settle_timer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | modem_settle_timer : 8-bit loadable down-counter with a zero flag        |
// | Revision           : 1.0                                                 |
// +--------------------------------------------------------------------------+
module modem_settle_timer (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       en,
  output logic       zero
);

  logic [7:0] r_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= 8'd0;
    end else if (load) begin
      r_count <= load_val;
    end else if (en && (r_count != 8'd0)) begin
      r_count <= r_count - 8'd1;
    end
  end

  assign zero = (r_count == 8'd0);

endmodule
`default_nettype wire

// File: rtl/modem_link_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | modem_link_sequencer : loopback self-test sweep of all 16 data codes     |
// | Revision             : 1.0                                               |
// +--------------------------------------------------------------------------+
module modem_link_sequencer
  import modem_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic             clk_slow,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [3:0]       manual_code,
  input  logic [3:0]       rx_code,
  output logic [3:0]       tx_code,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_cnt,
  output logic [3:0]       last_fail_code
);

  localparam logic [7:0]       C_SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_ERR_MAX     = '1;
  localparam logic [CNT_W-1:0] C_ERR_ONE     = CNT_W'(1);

  logic [2:0]       r_state;
  data_t            r_code;
  logic [CNT_W-1:0] r_err;
  data_t            r_last_fail;
  logic             r_done;
  logic             r_pass;
  logic             w_zero;
  logic             w_load;
  logic             w_en;

  assign w_load = (r_state == DRIVE);
  assign w_en   = (r_state == SETTLE);

  modem_settle_timer u_timer (
    .clk      (clk_slow),
    .reset    (reset),
    .load     (w_load),
    .load_val (C_SETTLE_LOAD),
    .en       (w_en),
    .zero     (w_zero)
  );

  always_ff @(posedge clk_slow or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_code      <= '0;
      r_err       <= '0;
      r_last_fail <= '0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
    end else if (abort && (r_state != IDLE)) begin
      // err_cnt and last_fail_code stay visible after an abort.
      r_state <= IDLE;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start && !abort) begin
            r_state     <= DRIVE;
            r_code      <= '0;
            r_err       <= '0;
            r_last_fail <= '0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
          end
        end
        DRIVE:  r_state <= SETTLE;
        SETTLE: if (w_zero) r_state <= SAMPLE;
        SAMPLE: begin
          if (rx_code != r_code) begin
            if (r_err != C_ERR_MAX) r_err <= r_err + C_ERR_ONE;
            r_last_fail <= r_code;
          end
          r_state <= NEXT;
        end
        NEXT: begin
          if (r_code == MAX_CODE) begin
            r_state <= DONE;
            r_done  <= 1'b1;
            r_pass  <= (r_err == '0);
          end else begin
            r_code  <= r_code + 4'd1;
            r_state <= DRIVE;
          end
        end
        DONE:    if (!start) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy           = is_busy_state(r_state);
  assign tx_code        = busy ? r_code : manual_code;
  assign done           = r_done;
  assign pass           = r_pass;
  assign err_cnt        = r_err;
  assign last_fail_code = r_last_fail;

endmodule
`default_nettype wire

// File: tb/tb_modem_link_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_modem_link_sequencer : directed checks of the loopback self-test      |
// | Revision                : 1.0                                            |
// +--------------------------------------------------------------------------+
module tb_modem_link_sequencer;

  logic       clk_slow = 1'b0;
  logic       reset;
  logic       start, abort;
  logic [3:0] manual_code, rx_code, tx_code, last_fail_code;
  logic       busy, done, pass;
  logic [7:0] err_cnt;
  logic [3:0] rx_mask;
  logic [3:0] d1, d2;

  logic [3:0] tx3, rx3, lf3;
  logic       busy3, done3, pass3;
  logic [2:0] err3;

  int tests  = 0;
  int failed = 0;

  always #5 clk_slow = ~clk_slow;

  // Loopback path model: two cycles of latency, optional stuck-at-0 bits.
  always @(posedge clk_slow) begin
    d1 <= tx_code;
    d2 <= d1;
  end
  assign rx_code = d2 & rx_mask;
  assign rx3     = ~tx3;

  modem_link_sequencer dut (
    .clk_slow       (clk_slow),
    .reset          (reset),
    .start          (start),
    .abort          (abort),
    .manual_code    (manual_code),
    .rx_code        (rx_code),
    .tx_code        (tx_code),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .err_cnt        (err_cnt),
    .last_fail_code (last_fail_code)
  );

  modem_link_sequencer #(.SETTLE_CYCLES(4), .CNT_W(3)) dut3 (
    .clk_slow       (clk_slow),
    .reset          (reset),
    .start          (start),
    .abort          (abort),
    .manual_code    (manual_code),
    .rx_code        (rx3),
    .tx_code        (tx3),
    .busy           (busy3),
    .done           (done3),
    .pass           (pass3),
    .err_cnt        (err3),
    .last_fail_code (lf3)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Starts a sweep and waits (bounded) for done; cyc = edges from start edge to done.
  task automatic run_sweep(input bit pulse, input bit track, output int cyc);
    cyc   = -1;
    start = 1'b1;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk_slow);
      if (pulse) start = 1'b0;
      if (done) begin
        cyc = k;
        break;
      end
      if (track && (k % 7 == 0) && (k < 112)) begin
        chk($sformatf("sweep_tx_k%0d", k), {28'd0, tx_code}, k / 7);
        chk($sformatf("sweep_busy_k%0d", k), {31'd0, busy}, 1);
      end
    end
    if (cyc < 0) begin
      tests++;
      failed++;
      $display("FAIL sweep_timeout: got no done, expected done within 300 cycles");
    end
  endtask

  typedef struct {
    logic       start;
    logic       abort;
    logic [3:0] manual;
    logic [3:0] exp_tx;
    logic       exp_busy;
  } idle_vec_t;

  idle_vec_t vecs[4];
  int        cyc;
  bit        found;

  initial begin
    vecs[0] = '{1'b0, 1'b0, 4'h3, 4'h3, 1'b0};
    vecs[1] = '{1'b0, 1'b0, 4'hC, 4'hC, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 4'h5, 4'h5, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 4'h9, 4'h9, 1'b0};

    // 1: reset with random inputs
    reset   = 1'b0;
    rx_mask = 4'hF;
    start = 1'b0; abort = 1'b0; manual_code = 4'h0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_slow);
      start       = 1'($urandom_range(0, 1));
      abort       = 1'($urandom_range(0, 1));
      manual_code = 4'($urandom_range(0, 15));
      #1;
      chk("rst_tx", {28'd0, tx_code}, {28'd0, manual_code});
      chk("rst_outs", {busy, done, pass, err_cnt, last_fail_code}, 0);
    end
    @(negedge clk_slow);
    start = 1'b0; abort = 1'b0;
    reset = 1'b1;

    // Idle passthrough table, including abort-over-start priority
    foreach (vecs[i]) begin
      start       = vecs[i].start;
      abort       = vecs[i].abort;
      manual_code = vecs[i].manual;
      @(negedge clk_slow);
      chk($sformatf("idle_tx_%0d", i), {28'd0, tx_code}, {28'd0, vecs[i].exp_tx});
      chk($sformatf("idle_busy_%0d", i), {31'd0, busy}, {31'd0, vecs[i].exp_busy});
    end
    start = 1'b0; abort = 1'b0; manual_code = 4'h0;
    @(negedge clk_slow);

    // 2: ideal loopback; dut3 sees all-inverted loopback in parallel
    run_sweep(1'b1, 1'b1, cyc);
    chk("ideal_latency", cyc, 112);
    chk("ideal_pass", {31'd0, pass}, 1);
    chk("ideal_err", {24'd0, err_cnt}, 0);
    chk("ideal_lastfail", {28'd0, last_fail_code}, 0);
    // 5: 3-bit counter saturates at 7
    chk("sat_done", {31'd0, done3}, 1);
    chk("sat_err", {29'd0, err3}, 7);
    chk("sat_pass", {31'd0, pass3}, 0);
    chk("sat_lastfail", {28'd0, lf3}, 4'hF);
    @(negedge clk_slow);
    chk("ideal_done_idle_busy", {31'd0, busy}, 0);
    chk("ideal_done_held", {31'd0, done}, 1);

    // 4: abort at code 6 with bit 2 stuck low
    rx_mask = 4'b1011;
    start   = 1'b1;
    @(negedge clk_slow);
    start = 1'b0;
    chk("restart_clears_done", {31'd0, done}, 0);
    found = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (busy && tx_code == 4'h6) begin
        found = 1'b1;
        break;
      end
      @(negedge clk_slow);
    end
    chk("abort_reach_code6", {31'd0, found}, 1);
    abort = 1'b1;
    @(negedge clk_slow);
    abort = 1'b0;
    chk("abort_busy", {31'd0, busy}, 0);
    chk("abort_done", {31'd0, done}, 0);
    chk("abort_err_kept", {24'd0, err_cnt}, 2);
    chk("abort_lastfail_kept", {28'd0, last_fail_code}, 4'h5);
    @(negedge clk_slow);
    chk("abort_stays_idle", {31'd0, busy}, 0);
    start = 1'b1;
    @(negedge clk_slow);
    start = 1'b0;
    chk("restart_err_clear", {24'd0, err_cnt}, 0);
    chk("restart_lastfail_clear", {28'd0, last_fail_code}, 0);
    chk("restart_code0", {28'd0, tx_code}, 0);
    chk("restart_busy", {31'd0, busy}, 1);

    // 3: finish that sweep with bit 2 stuck low
    found = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk_slow);
      if (done) begin
        found = 1'b1;
        break;
      end
    end
    chk("stuck_done", {31'd0, found}, 1);
    chk("stuck_err", {24'd0, err_cnt}, 8);
    chk("stuck_lastfail", {28'd0, last_fail_code}, 4'hF);
    chk("stuck_pass", {31'd0, pass}, 0);

    // 6: start held high through DONE
    rx_mask = 4'hF;
    @(negedge clk_slow);
    run_sweep(1'b0, 1'b0, cyc);
    chk("held_latency", cyc, 112);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_slow);
      chk($sformatf("held_no_retrigger_%0d", k), {30'd0, busy, done}, 2'b01);
    end
    start       = 1'b0;
    manual_code = 4'hA;
    @(negedge clk_slow);
    chk("drop_tx_manual", {28'd0, tx_code}, 4'hA);
    chk("drop_done_kept", {31'd0, done}, 1);
    chk("drop_pass_kept", {31'd0, pass}, 1);
    @(negedge clk_slow);
    chk("drop_idle_busy", {31'd0, busy}, 0);

    // Reset mid-sweep drops everything immediately
    start = 1'b1;
    @(negedge clk_slow);
    start = 1'b0;
    repeat (20) @(negedge clk_slow);
    chk("mid_busy_before", {31'd0, busy}, 1);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_outs", {busy, done, pass, err_cnt, last_fail_code}, 0);
    chk("mid_rst_err3", {29'd0, err3}, 0);
    chk("mid_rst_tx", {28'd0, tx_code}, {28'd0, manual_code});
    @(negedge clk_slow);
    reset = 1'b1;

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
`default_nettype wire
